// File: rtl/uart_frame_loader.sv
// UART-side command loader: parses framed write commands, buffers them in a FIFO
// and issues one-cycle CPU load strobes. Optional checksum byte: UART_FRAME_CHECKSUM_EN.
module uart_frame_loader #(
   parameter int DATA_W      = 16,
   parameter int SEL_W       = 2,
   parameter int FIFO_DEPTH  = 4,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          rx_valid,
   input  logic [7:0]                    rx_byte,
   output logic                          rx_ready,
   input  logic                          cpu_busy,
   output logic                          cpu_en,
   output logic [SEL_W-1:0]              cpu_sel,
   output logic [DATA_W-1:0]             cpu_data,
   output logic                          frame_err,
   output logic [7:0]                    err_cnt,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int NB      = DATA_W / 8;
   localparam int CNT_W   = $clog2(NB) + 1;
   localparam int TO_W    = $clog2(TIMEOUT_CYC) + 1;
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int LVL_W   = PTR_W + 1;
   localparam int ENTRY_W = SEL_W + DATA_W;

`ifdef UART_FRAME_CHECKSUM_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1, S_CSUM = 2'd2} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1} state_t;
`endif

   state_t              r_state;
   state_t              w_state_next;

   logic [DATA_W-1:0]   r_word;
   logic [SEL_W-1:0]    r_sel;
   logic [CNT_W-1:0]    r_byte_cnt;
   logic [TO_W-1:0]     r_to_cnt;
`ifdef UART_FRAME_CHECKSUM_EN
   logic [7:0]          r_xor;
`endif

   logic [ENTRY_W-1:0]  r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [LVL_W-1:0]    r_count;
   logic                r_rx_ready;
   logic                r_cpu_en;
   logic [SEL_W-1:0]    r_cpu_sel;
   logic [DATA_W-1:0]   r_cpu_data;
   logic                r_frame_err;
   logic [7:0]          r_err_cnt;

   logic                w_accept;
   logic                w_hdr_ok;
   logic                w_last;
   logic                w_timeout;
   logic                w_hdr_load;
   logic                w_shift;
   logic                w_push;
   logic                w_pop;
   logic                w_err;
   logic [DATA_W-1:0]   w_word_shift;
   logic [ENTRY_W-1:0]  w_push_data;
   logic [LVL_W-1:0]    w_count_next;

   assign w_accept     = rx_valid & r_rx_ready;
   assign w_hdr_ok     = (rx_byte[7:4] == 4'hA) && ((rx_byte[3:0] >> SEL_W) == 4'd0);
   assign w_last       = (r_byte_cnt == CNT_W'(NB - 1));
   assign w_timeout    = (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
   assign w_word_shift = (r_word << 8) | DATA_W'(rx_byte);
   assign w_pop        = (r_count != '0) && !cpu_busy;

`ifdef UART_FRAME_CHECKSUM_EN
   assign w_push_data  = {r_sel, r_word};
`else
   assign w_push_data  = {r_sel, w_word_shift};
`endif

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the case can leave a signal unassigned and infer a latch.
   always_comb begin
      w_state_next = r_state;
      w_hdr_load   = 1'b0;
      w_shift      = 1'b0;
      w_push       = 1'b0;
      w_err        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_hdr_ok) begin
                  w_hdr_load   = 1'b1;
                  w_state_next = S_DATA;
               end else begin
                  w_err = 1'b1;
               end
            end
         end
         S_DATA: begin
            // An accepted byte takes priority over an expiring timeout.
            if (w_accept) begin
               w_shift = 1'b1;
               if (w_last) begin
`ifdef UART_FRAME_CHECKSUM_EN
                  w_state_next = S_CSUM;
`else
                  w_push       = 1'b1;
                  w_state_next = S_IDLE;
`endif
               end
            end else if (w_timeout) begin
               w_err        = 1'b1;
               w_state_next = S_IDLE;
            end
         end
`ifdef UART_FRAME_CHECKSUM_EN
         S_CSUM: begin
            if (w_accept) begin
               if (rx_byte == r_xor) w_push = 1'b1;
               else                  w_err  = 1'b1;
               w_state_next = S_IDLE;
            end else if (w_timeout) begin
               w_err        = 1'b1;
               w_state_next = S_IDLE;
            end
         end
`endif
         default: w_state_next = S_IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_word     <= '0;
         r_sel      <= '0;
         r_byte_cnt <= '0;
         r_to_cnt   <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
         r_xor      <= '0;
`endif
      end else begin
         if (w_hdr_load) begin
            r_sel      <= rx_byte[SEL_W-1:0];
            r_word     <= '0;
            r_byte_cnt <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
            r_xor      <= rx_byte;
`endif
         end else if (w_shift) begin
            r_word     <= w_word_shift;
            r_byte_cnt <= r_byte_cnt + 1'b1;
`ifdef UART_FRAME_CHECKSUM_EN
            r_xor      <= r_xor ^ rx_byte;
`endif
         end

         if (r_state == S_IDLE || w_accept) r_to_cnt <= '0;
         else                               r_to_cnt <= r_to_cnt + 1'b1;
      end
   end

   always_comb begin
      w_count_next = r_count;
      if (w_push && !w_pop)      w_count_next = r_count + 1'b1;
      else if (!w_push && w_pop) w_count_next = r_count - 1'b1;
   end

   // NOTE: the storage array is deliberately not reset; the pointers and
   // count define validity, and a reset-free array maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_push_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_rx_ready  <= 1'b0;
         r_cpu_en    <= 1'b0;
         r_cpu_sel   <= '0;
         r_cpu_data  <= '0;
         r_frame_err <= 1'b0;
         r_err_cnt   <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) begin
            r_rd_ptr                <= r_rd_ptr + 1'b1;
            {r_cpu_sel, r_cpu_data} <= r_mem[r_rd_ptr];
         end
         r_cpu_en    <= w_pop;
         r_count     <= w_count_next;
         // Ready looks at the post-edge occupancy so a full FIFO never takes a byte.
         r_rx_ready  <= (w_count_next != LVL_W'(FIFO_DEPTH));
         r_frame_err <= w_err;
         if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 1'b1;
      end
   end

   assign rx_ready   = r_rx_ready;
   assign cpu_en     = r_cpu_en;
   assign cpu_sel    = r_cpu_sel;
   assign cpu_data   = r_cpu_data;
   assign frame_err  = r_frame_err;
   assign err_cnt    = r_err_cnt;
   assign fifo_level = r_count;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Self-checking bench for uart_frame_loader: directed scenarios plus randomized
// frames, scored against a byte-stream reference model.
module tb_uart_frame_loader;

   localparam int DATA_W      = 16;
   localparam int SEL_W       = 2;
   localparam int FIFO_DEPTH  = 4;
   localparam int TIMEOUT_CYC = 1000;
   localparam int NB          = DATA_W / 8;
`ifdef UART_FRAME_CHECKSUM_EN
   localparam bit CSUM        = 1'b1;
   localparam int FRAME_LEN   = NB + 2;
`else
   localparam bit CSUM        = 1'b0;
   localparam int FRAME_LEN   = NB + 1;
`endif
   localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 rx_valid = 1'b0;
   logic [7:0]           rx_byte = 8'h00;
   logic                 rx_ready;
   logic                 cpu_busy = 1'b0;
   logic                 cpu_en;
   logic [SEL_W-1:0]     cpu_sel;
   logic [DATA_W-1:0]    cpu_data;
   logic                 frame_err;
   logic [7:0]           err_cnt;
   logic [LVL_W-1:0]     fifo_level;

   uart_frame_loader #(
      .DATA_W(DATA_W), .SEL_W(SEL_W), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte),
      .rx_ready(rx_ready), .cpu_busy(cpu_busy), .cpu_en(cpu_en), .cpu_sel(cpu_sel),
      .cpu_data(cpu_data), .frame_err(frame_err), .err_cnt(err_cnt), .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Observed strobes and error pulses, captured mid-cycle.
   logic [SEL_W+DATA_W-1:0] obs_q[$];
   int                      err_pulses = 0;
   always @(negedge clk) begin
      if (cpu_en)    obs_q.push_back({cpu_sel, cpu_data});
      if (frame_err) err_pulses++;
   end

   // Reference model state.
   logic [7:0]              m_buf[$];
   logic [SEL_W+DATA_W-1:0] exp_q[$];
   int                      m_err;
   int                      obs_base;
   int                      err_base;
   bit                      rand_busy = 1'b0;

   task automatic model_clear();
      m_buf.delete();
      exp_q.delete();
      m_err    = 0;
      obs_base = obs_q.size();
      err_base = err_pulses;
   endtask

   task automatic model_byte(input logic [7:0] b);
      logic [DATA_W-1:0] word;
      logic [7:0]        x;
      m_buf.push_back(b);
      if (m_buf.size() == 1) begin
         if ((b >> 4) != 8'hA || int'(b & 8'h0F) >= (1 << SEL_W)) begin
            m_err++;
            m_buf.delete();
         end
      end else if (m_buf.size() == FRAME_LEN) begin
         word = '0;
         x    = 8'h00;
         for (int i = 1; i <= NB; i++) word = (word << 8) | DATA_W'(m_buf[i]);
         for (int i = 0; i <= NB; i++) x = x ^ m_buf[i];
         if (CSUM && x != m_buf[FRAME_LEN-1]) m_err++;
         else exp_q.push_back({SEL_W'(m_buf[0] & 8'h0F), word});
         m_buf.delete();
      end
   endtask

   task automatic model_abort();
      if (m_buf.size() > 0) begin
         m_err++;
         m_buf.delete();
      end
   endtask

   task automatic tick();
      if (rand_busy) cpu_busy = ($urandom_range(0, 3) == 0);
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      bit got;
      bit ok = 1'b0;
      rx_byte  = b;
      rx_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         got = rx_ready;
         tick();
         if (got) begin
            ok = 1'b1;
            break;
         end
      end
      rx_valid = 1'b0;
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL send_byte: byte %02h not accepted within 300 cycles", b);
      end else begin
         model_byte(b);
      end
      for (int i = 0; i < gap; i++) tick();
   endtask

   task automatic send_frame(input logic [SEL_W-1:0] sel, input logic [DATA_W-1:0] data,
                             input bit corrupt, input int gap);
      logic [7:0] fb[$];
      logic [7:0] x;
      fb.push_back(8'hA0 | 8'(sel));
      for (int i = NB - 1; i >= 0; i--) fb.push_back(data[8*i +: 8]);
      if (CSUM) begin
         x = 8'h00;
         foreach (fb[k]) x = x ^ fb[k];
         if (corrupt) x = x ^ 8'h5A;
         fb.push_back(x);
      end
      foreach (fb[k]) send_byte(fb[k], (k == fb.size() - 1) ? 0 : gap);
   endtask

   task automatic do_reset();
      rx_valid = 1'b0;
      cpu_busy = 1'b0;
      reset    = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      model_clear();
   endtask

   task automatic drain();
      bit done = 1'b0;
      rand_busy = 1'b0;
      cpu_busy  = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (fifo_level == '0 && !cpu_en) begin
            done = 1'b1;
            break;
         end
         tick();
      end
      tick();
      tick();
      n_tests++;
      if (!done) begin
         n_fail++;
         $display("FAIL drain: fifo_level=%0d did not empty within 60 cycles", fifo_level);
      end
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      rx_valid = 1'b0;
      cpu_busy = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_tests++; if (rx_ready !== 1'b0)   begin n_fail++; $display("FAIL reset_rx_ready: got %b want 0", rx_ready); end
      n_tests++; if (cpu_en !== 1'b0)     begin n_fail++; $display("FAIL reset_cpu_en: got %b want 0", cpu_en); end
      n_tests++; if (cpu_sel !== '0)      begin n_fail++; $display("FAIL reset_cpu_sel: got %0d want 0", cpu_sel); end
      n_tests++; if (cpu_data !== '0)     begin n_fail++; $display("FAIL reset_cpu_data: got %0h want 0", cpu_data); end
      n_tests++; if (frame_err !== 1'b0)  begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
      n_tests++; if (err_cnt !== 8'd0)    begin n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
      n_tests++; if (fifo_level !== '0)   begin n_fail++; $display("FAIL reset_fifo_level: got %0d want 0", fifo_level); end
      reset = 1'b0;
      @(posedge clk);
      #1;
      n_tests++; if (rx_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", rx_ready); end
      model_clear();
   endtask

   task automatic test_basic();
      do_reset();
      send_frame(2'd1, 16'd10, 1'b0, 1);
      n_tests++; if (fifo_level !== LVL_W'(1)) begin n_fail++; $display("FAIL basic_level: got %0d want 1", fifo_level); end
      n_tests++; if (cpu_en !== 1'b0)          begin n_fail++; $display("FAIL basic_early_en: got %b want 0", cpu_en); end
      @(posedge clk); #1;
      n_tests++; if (cpu_en !== 1'b1)          begin n_fail++; $display("FAIL basic_en: got %b want 1", cpu_en); end
      n_tests++; if ({cpu_sel, cpu_data} !== {2'd1, 16'd10})
         begin n_fail++; $display("FAIL basic_load: got sel=%0d data=%0d want sel=1 data=10", cpu_sel, cpu_data); end
      @(posedge clk); #1;
      n_tests++; if (cpu_en !== 1'b0)          begin n_fail++; $display("FAIL basic_pulse: got %b want 0", cpu_en); end
      n_tests++; if (cpu_data !== 16'd10)      begin n_fail++; $display("FAIL basic_hold: got %0d want 10", cpu_data); end
      n_tests++; if (err_cnt !== 8'd0)         begin n_fail++; $display("FAIL basic_err_cnt: got %0d want 0", err_cnt); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      cpu_busy = 1'b1;
      send_frame(2'd1, 16'd10, 1'b0, $urandom_range(0, 2));
      send_frame(2'd1, 16'd30, 1'b0, $urandom_range(0, 2));
      send_frame(2'd2, 16'd100, 1'b0, $urandom_range(0, 2));
      repeat (3) begin @(posedge clk); #1; end
      n_tests++; if (fifo_level !== LVL_W'(3)) begin n_fail++; $display("FAIL b2b_level: got %0d want 3", fifo_level); end
      n_tests++; if (obs_q.size() != obs_base) begin n_fail++; $display("FAIL b2b_busy_hold: got %0d strobes want 0", obs_q.size() - obs_base); end
      cpu_busy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_tests++;
         if (!cpu_en || exp_q.size() <= i || {cpu_sel, cpu_data} !== exp_q[i]) begin
            n_fail++;
            $display("FAIL b2b_strobe%0d: got en=%b sel=%0d data=%0d want en=1 %0h", i, cpu_en, cpu_sel, cpu_data,
                     (exp_q.size() > i) ? exp_q[i] : '0);
         end
      end
      @(posedge clk); #1;
      n_tests++; if (cpu_en !== 1'b0 || fifo_level !== '0)
         begin n_fail++; $display("FAIL b2b_end: got en=%b level=%0d want en=0 level=0", cpu_en, fifo_level); end
   endtask

   task automatic test_errors();
      do_reset();
      send_byte(8'h51, 0);
      n_tests++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL err_pulse: got %b want 1", frame_err); end
      @(posedge clk); #1;
      n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL err_pulse_width: got %b want 0", frame_err); end
      n_tests++; if (err_cnt !== 8'(m_err)) begin n_fail++; $display("FAIL err_hdr_cnt: got %0d want %0d", err_cnt, m_err); end
      send_byte(8'hA1, 1);
      send_byte(8'h00, 1);
      send_byte(8'h0A, 1);
      send_byte(8'h00, 0);
      drain();
      n_tests++; if (err_cnt !== 8'(m_err)) begin n_fail++; $display("FAIL err_csum_cnt: got %0d want %0d", err_cnt, m_err); end
      n_tests++; if (err_pulses - err_base != m_err)
         begin n_fail++; $display("FAIL err_pulses: got %0d want %0d", err_pulses - err_base, m_err); end
      n_tests++; if (obs_q.size() - obs_base != exp_q.size())
         begin n_fail++; $display("FAIL err_strobes: got %0d want %0d", obs_q.size() - obs_base, exp_q.size()); end
   endtask

   task automatic test_timeout();
      do_reset();
      send_byte(8'hA1, 0);
      send_byte(8'h00, 0);
      repeat (TIMEOUT_CYC - 2) @(posedge clk);
      #1;
      n_tests++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL timeout_early: got %0d want 0", err_cnt); end
      repeat (10) @(posedge clk);
      #1;
      model_abort();
      n_tests++; if (err_cnt !== 8'(m_err)) begin n_fail++; $display("FAIL timeout_cnt: got %0d want %0d", err_cnt, m_err); end
      n_tests++; if (err_pulses - err_base != 1)
         begin n_fail++; $display("FAIL timeout_pulse: got %0d pulses want 1", err_pulses - err_base); end
      send_frame(2'd2, 16'd100, 1'b0, 1);
      drain();
      n_tests++;
      if (obs_q.size() - obs_base != 1 || exp_q.size() != 1 || obs_q[obs_base] !== exp_q[0]) begin
         n_fail++;
         $display("FAIL timeout_recover: got %0d strobes want 1 of %0h", obs_q.size() - obs_base, {2'd2, 16'd100});
      end
   endtask

   task automatic test_backpressure();
      logic [DATA_W-1:0] d5;
      do_reset();
      cpu_busy = 1'b1;
      for (int f = 0; f < FIFO_DEPTH; f++)
         send_frame(SEL_W'($urandom_range(0, 3)), DATA_W'($urandom), 1'b0, $urandom_range(0, 1));
      repeat (2) begin @(posedge clk); #1; end
      n_tests++; if (fifo_level !== LVL_W'(FIFO_DEPTH)) begin n_fail++; $display("FAIL bp_full: got %0d want %0d", fifo_level, FIFO_DEPTH); end
      n_tests++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b want 0", rx_ready); end
      rx_byte  = 8'hA3;
      rx_valid = 1'b1;
      repeat (5) begin @(posedge clk); #1; end
      n_tests++; if (fifo_level !== LVL_W'(FIFO_DEPTH) || err_cnt !== 8'd0)
         begin n_fail++; $display("FAIL bp_stall: got level=%0d err=%0d want %0d,0", fifo_level, err_cnt, FIFO_DEPTH); end
      cpu_busy = 1'b0;
      @(posedge clk); #1;
      cpu_busy = 1'b1;
      rx_valid = 1'b0;
      n_tests++; if (rx_ready !== 1'b1 || cpu_en !== 1'b1)
         begin n_fail++; $display("FAIL bp_pop_ready: got ready=%b en=%b want 1,1", rx_ready, cpu_en); end
      d5 = DATA_W'($urandom);
      send_frame(2'd3, d5, 1'b0, 0);
      n_tests++; if (fifo_level !== LVL_W'(FIFO_DEPTH)) begin n_fail++; $display("FAIL bp_fifth: got %0d want %0d", fifo_level, FIFO_DEPTH); end
      drain();
      n_tests++;
      if (obs_q.size() - obs_base != exp_q.size()) begin
         n_fail++;
         $display("FAIL bp_count: got %0d strobes want %0d", obs_q.size() - obs_base, exp_q.size());
      end else begin
         foreach (exp_q[i])
            if (obs_q[obs_base+i] !== exp_q[i]) begin
               n_fail++;
               $display("FAIL bp_entry%0d: got %0h want %0h", i, obs_q[obs_base+i], exp_q[i]);
            end
      end
   endtask

   task automatic test_reset_midframe();
      do_reset();
      cpu_busy = 1'b1;
      send_frame(2'd3, 16'h1234, 1'b0, 0);
      send_byte(8'hA1, 0);
      send_byte(8'h00, 0);
      reset = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if ({rx_ready, cpu_en, cpu_sel, cpu_data, frame_err, err_cnt, fifo_level} !== '0) begin
         n_fail++;
         $display("FAIL midreset_outputs: got ready=%b en=%b sel=%0d data=%0h err=%b cnt=%0d lvl=%0d want all 0",
                  rx_ready, cpu_en, cpu_sel, cpu_data, frame_err, err_cnt, fifo_level);
      end
      reset    = 1'b0;
      cpu_busy = 1'b0;
      model_clear();
      @(posedge clk); #1;
      send_frame(2'd2, 16'd100, 1'b0, 1);
      drain();
      n_tests++;
      if (obs_q.size() - obs_base != 1 || obs_q[obs_base] !== {2'd2, 16'd100}) begin
         n_fail++;
         $display("FAIL midreset_strobe: got %0d strobes (first %0h) want exactly one %0h",
                  obs_q.size() - obs_base, (obs_q.size() > obs_base) ? obs_q[obs_base] : '0, {2'd2, 16'd100});
      end
      n_tests++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL midreset_err: got %0d want 0", err_cnt); end
   endtask

   task automatic test_random();
      int kind;
      do_reset();
      rand_busy = 1'b1;
      for (int f = 0; f < 40; f++) begin
         kind = $urandom_range(0, 9);
         if (kind == 0)
            send_byte(($urandom_range(0, 1) == 1) ? (8'h50 | 8'($urandom_range(0, 15)))
                                                  : (8'hA4 | 8'($urandom_range(0, 11))), $urandom_range(0, 2));
         else
            send_frame(SEL_W'($urandom_range(0, 3)), DATA_W'($urandom), kind == 1, $urandom_range(0, 2));
      end
      drain();
      n_tests++;
      if (obs_q.size() - obs_base != exp_q.size()) begin
         n_fail++;
         $display("FAIL rand_count: got %0d strobes want %0d", obs_q.size() - obs_base, exp_q.size());
      end else begin
         foreach (exp_q[i])
            if (obs_q[obs_base+i] !== exp_q[i]) begin
               n_fail++;
               $display("FAIL rand_entry%0d: got %0h want %0h", i, obs_q[obs_base+i], exp_q[i]);
            end
      end
      n_tests++; if (err_cnt !== 8'((m_err > 255) ? 255 : m_err))
         begin n_fail++; $display("FAIL rand_err_cnt: got %0d want %0d", err_cnt, m_err); end
      n_tests++; if (err_pulses - err_base != m_err)
         begin n_fail++; $display("FAIL rand_pulses: got %0d want %0d", err_pulses - err_base, m_err); end
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_errors();
      test_timeout();
      test_backpressure();
      test_reset_midframe();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
